axi_xfer_checker: RTL and testbench

// - Verification checker: confirms that AXI traffic entering one end of a link
//   (side A) reappears unchanged at the other end (side B), beat by beat, per channel.
// - AW, W and AR beats flow from side A to side B. B and R beats flow from side B to side A.
// - Passive: drives nothing onto either bus. Used in link benches (e.g. serial link A->B) to flag corruption, loss or reordering.

---
 rtl/axi_xfer_checker_pkg.sv | 93 +++++++++
 rtl/axi_xfer_checker_fifo.sv | 74 +++++++
 rtl/axi_xfer_checker.sv | 184 ++++++++++++++++++
 tb/tb_axi_xfer_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_xfer_checker_pkg.sv
// Shared types and helpers for the AXI link transfer checker: default channel
// payloads, channel index enum, id masking and gray-code conversion.
package axi_xfer_checker_pkg;

    localparam int unsigned IdW    = 4;
    localparam int unsigned AddrW  = 32;
    localparam int unsigned DataW  = 64;
    localparam int unsigned UserW  = 1;
    localparam int unsigned NumCh  = 5;
    localparam int unsigned EvCntW = 4;

    typedef enum logic [2:0] {
        CH_AW = 3'd0,
        CH_W  = 3'd1,
        CH_B  = 3'd2,
        CH_AR = 3'd3,
        CH_R  = 3'd4
    } chan_e;

    typedef logic [IdW-1:0]    id_t;
    typedef logic [EvCntW-1:0] evcnt_t;

    typedef struct packed {
        id_t              id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [UserW-1:0] user;
    } axi_aw_t;

    typedef axi_aw_t axi_ar_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        id_t              id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } axi_b_t;

    typedef struct packed {
        id_t              id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;

    function automatic id_t mask_id(input id_t id, input logic ignore_id);
        return ignore_id ? '0 : id;
    endfunction

    function automatic evcnt_t bin2gray(input evcnt_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic evcnt_t gray2bin(input evcnt_t g);
        evcnt_t b;
        b = '0;
        for (int unsigned i = 0; i < EvCntW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/axi_xfer_checker_fifo.sv
// Dual-clock in-order store; pointers cross domains gray-coded through two flops.
module axi_xfer_checker_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 64
) (
    input  logic wclk_i,
    input  logic rclk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     wdata_i,
    output logic full_o,
    input  logic pop_i,
    output T     rdata_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    typedef logic [AW:0] ptr_t;

    function automatic ptr_t b2g(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t g2b(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int unsigned i = 0; i <= AW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    T     mem_q [Depth];
    ptr_t wbin_q, wgray_q, rgray_w1_q, rgray_w2_q;
    ptr_t rbin_q, rgray_q, wgray_r1_q, wgray_r2_q;
    ptr_t wbin_d, rbin_d, wcount, rcount;

    assign wcount  = wbin_q - g2b(rgray_w2_q);
    assign rcount  = g2b(wgray_r2_q) - rbin_q;
    assign full_o  = (wcount == ptr_t'(Depth));
    assign empty_o = (rcount == '0);
    assign wbin_d  = wbin_q + ptr_t'(push_i & ~full_o);
    assign rbin_d  = rbin_q + ptr_t'(pop_i & ~empty_o);
    assign rdata_o = mem_q[rbin_q[AW-1:0]];

    always_ff @(posedge wclk_i) begin
        if (push_i && !full_o) begin
            mem_q[wbin_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge wclk_i or posedge rst_i) begin
        if (rst_i) begin
            {wbin_q, wgray_q, rgray_w1_q, rgray_w2_q} <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= b2g(wbin_d);
            rgray_w1_q <= rgray_q;
            rgray_w2_q <= rgray_w1_q;
        end
    end

    always_ff @(posedge rclk_i or posedge rst_i) begin
        if (rst_i) begin
            {rbin_q, rgray_q, wgray_r1_q, wgray_r2_q} <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= b2g(rbin_d);
            wgray_r1_q <= wgray_q;
            wgray_r2_q <= wgray_r1_q;
        end
    end

endmodule

// File: rtl/axi_xfer_checker.sv
// Passive link checker: every AXI beat entering one side must leave the other
// side unchanged and in order, per channel. All error state lives in clk_1.
module axi_xfer_checker
    import axi_xfer_checker_pkg::*;
#(
    parameter logic        IgnoreId  = 1'b0,
    parameter int unsigned Depth     = 64,
    parameter logic        ReportErr = 1'b1,
    parameter type         aw_chan_t = axi_xfer_checker_pkg::axi_aw_t,
    parameter type         w_chan_t  = axi_xfer_checker_pkg::axi_w_t,
    parameter type         b_chan_t  = axi_xfer_checker_pkg::axi_b_t,
    parameter type         ar_chan_t = axi_xfer_checker_pkg::axi_ar_t,
    parameter type         r_chan_t  = axi_xfer_checker_pkg::axi_r_t,
    parameter type         req_t     = axi_xfer_checker_pkg::axi_req_t,
    parameter type         resp_t    = axi_xfer_checker_pkg::axi_resp_t
) (
    input  logic        clk_1,
    input  logic        rst_1_n,
    input  logic        clk_2,
    input  req_t        a_req_i,
    input  resp_t       a_rsp_i,
    input  req_t        b_req_i,
    input  resp_t       b_rsp_i,
    output logic [4:0]  mismatch_o,
    output logic [4:0]  overflow_o,
    output logic [31:0] err_cnt_o
);

    // Channels whose compare happens on clk_2 (sinks on side B); the rest compare on clk_1.
    localparam logic [NumCh-1:0] SinkOnClk2 = 5'b01011;

    logic     aw_push, w_push, ar_push, b_push, r_push;
    logic     aw_pop, w_pop, ar_pop, b_pop, r_pop;
    logic     aw_full, w_full, ar_full, b_full, r_full;
    logic     aw_empty, w_empty, ar_empty, b_empty, r_empty;
    aw_chan_t aw_head, aw_exp, aw_act;
    w_chan_t  w_head, w_exp, w_act;
    ar_chan_t ar_head, ar_exp, ar_act;
    b_chan_t  b_head, b_exp, b_act;
    r_chan_t  r_head, r_exp, r_act;

    assign aw_push = a_req_i.aw_valid & a_rsp_i.aw_ready;
    assign w_push  = a_req_i.w_valid  & a_rsp_i.w_ready;
    assign ar_push = a_req_i.ar_valid & a_rsp_i.ar_ready;
    assign b_push  = b_rsp_i.b_valid  & b_req_i.b_ready;
    assign r_push  = b_rsp_i.r_valid  & b_req_i.r_ready;
    assign aw_pop  = b_req_i.aw_valid & b_rsp_i.aw_ready;
    assign w_pop   = b_req_i.w_valid  & b_rsp_i.w_ready;
    assign ar_pop  = b_req_i.ar_valid & b_rsp_i.ar_ready;
    assign b_pop   = a_rsp_i.b_valid  & a_req_i.b_ready;
    assign r_pop   = a_rsp_i.r_valid  & a_req_i.r_ready;

    axi_xfer_checker_fifo #(.T(aw_chan_t), .Depth(Depth)) u_aw_fifo (
        .wclk_i(clk_1), .rclk_i(clk_2), .rst_i(rst_1_n), .push_i(aw_push), .wdata_i(a_req_i.aw),
        .full_o(aw_full), .pop_i(aw_pop), .rdata_o(aw_head), .empty_o(aw_empty));
    axi_xfer_checker_fifo #(.T(w_chan_t), .Depth(Depth)) u_w_fifo (
        .wclk_i(clk_1), .rclk_i(clk_2), .rst_i(rst_1_n), .push_i(w_push), .wdata_i(a_req_i.w),
        .full_o(w_full), .pop_i(w_pop), .rdata_o(w_head), .empty_o(w_empty));
    axi_xfer_checker_fifo #(.T(ar_chan_t), .Depth(Depth)) u_ar_fifo (
        .wclk_i(clk_1), .rclk_i(clk_2), .rst_i(rst_1_n), .push_i(ar_push), .wdata_i(a_req_i.ar),
        .full_o(ar_full), .pop_i(ar_pop), .rdata_o(ar_head), .empty_o(ar_empty));
    axi_xfer_checker_fifo #(.T(b_chan_t), .Depth(Depth)) u_b_fifo (
        .wclk_i(clk_2), .rclk_i(clk_1), .rst_i(rst_1_n), .push_i(b_push), .wdata_i(b_rsp_i.b),
        .full_o(b_full), .pop_i(b_pop), .rdata_o(b_head), .empty_o(b_empty));
    axi_xfer_checker_fifo #(.T(r_chan_t), .Depth(Depth)) u_r_fifo (
        .wclk_i(clk_2), .rclk_i(clk_1), .rst_i(rst_1_n), .push_i(r_push), .wdata_i(b_rsp_i.r),
        .full_o(r_full), .pop_i(r_pop), .rdata_o(r_head), .empty_o(r_empty));

    // ev2: events detected on clk_2; ev1: events detected on clk_1.
    logic [NumCh-1:0] ev1, ev2;

    always_comb begin
        aw_exp = aw_head;  aw_act = b_req_i.aw;
        w_exp  = w_head;   w_act  = b_req_i.w;
        ar_exp = ar_head;  ar_act = b_req_i.ar;
        b_exp  = b_head;   b_act  = a_rsp_i.b;
        r_exp  = r_head;   r_act  = a_rsp_i.r;
        aw_exp.id = mask_id(aw_exp.id, IgnoreId);
        aw_act.id = mask_id(aw_act.id, IgnoreId);
        ar_exp.id = mask_id(ar_exp.id, IgnoreId);
        ar_act.id = mask_id(ar_act.id, IgnoreId);
        b_exp.id  = mask_id(b_exp.id, IgnoreId);
        b_act.id  = mask_id(b_act.id, IgnoreId);
        r_exp.id  = mask_id(r_exp.id, IgnoreId);
        r_act.id  = mask_id(r_act.id, IgnoreId);
        ev1 = '0;
        ev2 = '0;
        ev2[CH_AW] = aw_pop & (aw_empty | (aw_exp != aw_act));
        ev2[CH_W]  = w_pop  & (w_empty  | (w_exp  != w_act));
        ev2[CH_AR] = ar_pop & (ar_empty | (ar_exp != ar_act));
        ev2[CH_B]  = b_push & b_full;
        ev2[CH_R]  = r_push & r_full;
        ev1[CH_B]  = b_pop  & (b_empty  | (b_exp  != b_act));
        ev1[CH_R]  = r_pop  & (r_empty  | (r_exp  != r_act));
        ev1[CH_AW] = aw_push & aw_full;
        ev1[CH_W]  = w_push  & w_full;
        ev1[CH_AR] = ar_push & ar_full;
    end

    // clk_2 events are counted per channel and the gray-coded count is handed to clk_1.
    evcnt_t cnt2_q [NumCh];
    evcnt_t cnt2_d [NumCh];
    evcnt_t gray2_q [NumCh];

    always_comb begin
        for (int unsigned i = 0; i < NumCh; i++) begin
            cnt2_d[i] = cnt2_q[i] + evcnt_t'(ev2[i]);
        end
    end

    always_ff @(posedge clk_2 or posedge rst_1_n) begin
        if (rst_1_n) begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                cnt2_q[i]  <= '0;
                gray2_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                cnt2_q[i]  <= cnt2_d[i];
                gray2_q[i] <= bin2gray(cnt2_d[i]);
            end
            if (ReportErr && ev2[CH_AW])
                $error("AW %s: expected %p actual %p", aw_empty ? "unexpected beat" : "mismatch", aw_exp, aw_act);
            if (ReportErr && ev2[CH_W])
                $error("W %s: expected %p actual %p", w_empty ? "unexpected beat" : "mismatch", w_exp, w_act);
            if (ReportErr && ev2[CH_AR])
                $error("AR %s: expected %p actual %p", ar_empty ? "unexpected beat" : "mismatch", ar_exp, ar_act);
        end
    end

    evcnt_t           sync1_q [NumCh];
    evcnt_t           sync2_q [NumCh];
    evcnt_t           seen_q [NumCh];
    evcnt_t           dlt [NumCh];
    logic [NumCh-1:0] dnz, mism_q, mism_d, ovf_q, ovf_d;
    logic [7:0]       inc;
    logic [32:0]      sum;
    logic [31:0]      err_q, err_d;

    always_comb begin
        inc = '0;
        dnz = '0;
        for (int unsigned i = 0; i < NumCh; i++) begin
            dlt[i] = gray2bin(sync2_q[i]) - seen_q[i];
            dnz[i] = |dlt[i];
            inc    = inc + 8'(dlt[i]) + 8'(ev1[i]);
        end
        mism_d = mism_q | (SinkOnClk2 & dnz) | (~SinkOnClk2 & ev1);
        ovf_d  = ovf_q | (~SinkOnClk2 & dnz) | (SinkOnClk2 & ev1);
        sum    = {1'b0, err_q} + 33'(inc);
        err_d  = sum[32] ? '1 : sum[31:0];
    end

    always_ff @(posedge clk_1 or posedge rst_1_n) begin
        if (rst_1_n) begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                sync1_q[i] <= '0;
                sync2_q[i] <= '0;
                seen_q[i]  <= '0;
            end
            mism_q <= '0;
            ovf_q  <= '0;
            err_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NumCh; i++) begin
                sync1_q[i] <= gray2_q[i];
                sync2_q[i] <= sync1_q[i];
                seen_q[i]  <= gray2bin(sync2_q[i]);
            end
            mism_q <= mism_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            if (ReportErr && ev1[CH_B])
                $error("B %s: expected %p actual %p", b_empty ? "unexpected beat" : "mismatch", b_exp, b_act);
            if (ReportErr && ev1[CH_R])
                $error("R %s: expected %p actual %p", r_empty ? "unexpected beat" : "mismatch", r_exp, r_act);
        end
    end

    assign mismatch_o = mism_q;
    assign overflow_o = ovf_q;
    assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_axi_xfer_checker.sv
// Directed bench for axi_xfer_checker: one instance compares ids, one ignores them.
module tb_axi_xfer_checker;
    import axi_xfer_checker_pkg::*;

    localparam int unsigned N   = 100;
    localparam int unsigned Lag = 8;

    logic        clk_1, clk_2, rst_1_n;
    axi_req_t    a_req, b_req;
    axi_resp_t   a_rsp, b_rsp;
    logic [4:0]  mism0, ovf0, mism1, ovf1;
    logic [31:0] err0, err1;
    int unsigned n_tests, n_fail;

    axi_aw_t    aw_q [N];
    axi_w_t     w_q [N];
    axi_ar_t    ar_q [N];
    axi_b_t     b_q [N];
    axi_r_t     r_q [N];
    logic [4:0] v_q [N];

    axi_xfer_checker #(.IgnoreId(1'b0), .Depth(64), .ReportErr(1'b0)) u_dut (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .clk_2(clk_2),
        .a_req_i(a_req), .a_rsp_i(a_rsp), .b_req_i(b_req), .b_rsp_i(b_rsp),
        .mismatch_o(mism0), .overflow_o(ovf0), .err_cnt_o(err0));

    axi_xfer_checker #(.IgnoreId(1'b1), .Depth(64), .ReportErr(1'b0)) u_dut_ign (
        .clk_1(clk_1), .rst_1_n(rst_1_n), .clk_2(clk_2),
        .a_req_i(a_req), .a_rsp_i(a_rsp), .b_req_i(b_req), .b_rsp_i(b_rsp),
        .mismatch_o(mism1), .overflow_o(ovf1), .err_cnt_o(err1));

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    initial begin
        clk_2 = 1'b0;
        #3 clk_2 = 1'b1;
        forever #5 clk_2 = ~clk_2;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk_1);
    endtask

    task automatic idle();
        a_req.aw_valid = 1'b0; a_req.w_valid = 1'b0; a_req.ar_valid = 1'b0;
        b_req.aw_valid = 1'b0; b_req.w_valid = 1'b0; b_req.ar_valid = 1'b0;
        a_rsp.b_valid  = 1'b0; a_rsp.r_valid = 1'b0;
        b_rsp.b_valid  = 1'b0; b_rsp.r_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_1_n = 1'b1;
        tick(2);
        rst_1_n = 1'b0;
        tick(3);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        a_req = '0; b_req = '0; a_rsp = '0; b_rsp = '0;
        a_rsp.aw_ready = 1'b1; a_rsp.w_ready = 1'b1; a_rsp.ar_ready = 1'b1;
        b_rsp.aw_ready = 1'b1; b_rsp.w_ready = 1'b1; b_rsp.ar_ready = 1'b1;
        a_req.b_ready  = 1'b1; a_req.r_ready = 1'b1;
        b_req.b_ready  = 1'b1; b_req.r_ready = 1'b1;
        rst_1_n = 1'b1;
        tick(3);
        check_eq("reset_mismatch", 64'(mism0), 64'h0);
        check_eq("reset_overflow", 64'(ovf0), 64'h0);
        check_eq("reset_errcnt", 64'(err0), 64'h0);
        rst_1_n = 1'b0;
        tick(3);

        // Matching AW forwarded 20 cycles later
        a_req.aw = '{id: 4'd2, addr: 32'h1000, len: 8'd3, size: 3'd3, burst: 2'd1, user: 1'b0};
        a_req.aw_valid = 1'b1;
        tick(1); idle(); tick(20);
        b_req.aw = '{id: 4'd2, addr: 32'h1000, len: 8'd3, size: 3'd3, burst: 2'd1, user: 1'b0};
        b_req.aw_valid = 1'b1;
        tick(1); idle(); tick(10);
        check_eq("aw_match_mismatch", 64'(mism0), 64'h0);
        check_eq("aw_match_errcnt", 64'(err0), 64'h0);

        // W data corrupted on the link
        do_reset();
        a_req.w = '{data: 64'hA5A5_A5A5_A5A5_A5A5, strb: 8'hFF, last: 1'b1, user: 1'b0};
        a_req.w_valid = 1'b1;
        tick(1); idle(); tick(10);
        b_req.w = '{data: 64'h5A5A_5A5A_5A5A_5A5A, strb: 8'hFF, last: 1'b1, user: 1'b0};
        b_req.w_valid = 1'b1;
        tick(1); idle(); tick(10);
        check_eq("w_corrupt_mismatch", 64'(mism0), 64'h02);
        check_eq("w_corrupt_errcnt", 64'(err0), 64'h1);

        // AR id remapped by the link
        do_reset();
        a_req.ar = '{id: 4'd3, addr: 32'h2000, len: 8'd0, size: 3'd2, burst: 2'd1, user: 1'b1};
        a_req.ar_valid = 1'b1;
        tick(1); idle(); tick(10);
        b_req.ar = '{id: 4'd7, addr: 32'h2000, len: 8'd0, size: 3'd2, burst: 2'd1, user: 1'b1};
        b_req.ar_valid = 1'b1;
        tick(1); idle(); tick(10);
        check_eq("ar_ignid_mismatch", 64'(mism1), 64'h0);
        check_eq("ar_ignid_errcnt", 64'(err1), 64'h0);
        check_eq("ar_id_mismatch", 64'(mism0), 64'h08);
        check_eq("ar_id_errcnt", 64'(err0), 64'h1);

        // R on side A with nothing sent from side B
        do_reset();
        a_rsp.r = '{id: 4'd1, data: 64'h1234, resp: 2'd0, last: 1'b1, user: 1'b0};
        a_rsp.r_valid = 1'b1;
        tick(1); idle(); tick(3);
        check_eq("r_unexp_mismatch", 64'(mism0), 64'h10);
        check_eq("r_unexp_errcnt", 64'(err0), 64'h1);

        // 65 AW with no sink: the 65th overflows the 64-entry store
        do_reset();
        for (int unsigned k = 0; k < 65; k++) begin
            a_req.aw = '{id: 4'(k), addr: 32'(k * 16), len: 8'd0, size: 3'd2, burst: 2'd1, user: 1'b0};
            a_req.aw_valid = 1'b1;
            tick(1);
        end
        idle(); tick(3);
        check_eq("ovf_overflow", 64'(ovf0), 64'h01);
        check_eq("ovf_errcnt", 64'(err0), 64'h1);
        check_eq("ovf_mismatch", 64'(mism0), 64'h0);

        // Random traffic forwarded with a fixed lag in both directions
        do_reset();
        for (int unsigned k = 0; k < N; k++) begin
            aw_q[k] = '{id: 4'($urandom), addr: $urandom, len: 8'($urandom), size: 3'($urandom),
                        burst: 2'($urandom), user: 1'($urandom)};
            ar_q[k] = '{id: 4'($urandom), addr: $urandom, len: 8'($urandom), size: 3'($urandom),
                        burst: 2'($urandom), user: 1'($urandom)};
            w_q[k]  = '{data: {$urandom, $urandom}, strb: 8'($urandom), last: 1'($urandom), user: 1'($urandom)};
            b_q[k]  = '{id: 4'($urandom), resp: 2'($urandom), user: 1'($urandom)};
            r_q[k]  = '{id: 4'($urandom), data: {$urandom, $urandom}, resp: 2'($urandom),
                        last: 1'($urandom), user: 1'($urandom)};
            v_q[k]  = 5'($urandom);
        end
        for (int unsigned k = 0; k < N + Lag; k++) begin
            idle();
            if (k < N) begin
                a_req.aw = aw_q[k]; a_req.aw_valid = v_q[k][0];
                a_req.w  = w_q[k];  a_req.w_valid  = v_q[k][1];
                b_rsp.b  = b_q[k];  b_rsp.b_valid  = v_q[k][2];
                a_req.ar = ar_q[k]; a_req.ar_valid = v_q[k][3];
                b_rsp.r  = r_q[k];  b_rsp.r_valid  = v_q[k][4];
            end
            if (k >= Lag) begin
                b_req.aw = aw_q[k-Lag]; b_req.aw_valid = v_q[k-Lag][0];
                b_req.w  = w_q[k-Lag];  b_req.w_valid  = v_q[k-Lag][1];
                a_rsp.b  = b_q[k-Lag];  a_rsp.b_valid  = v_q[k-Lag][2];
                b_req.ar = ar_q[k-Lag]; b_req.ar_valid = v_q[k-Lag][3];
                a_rsp.r  = r_q[k-Lag];  a_rsp.r_valid  = v_q[k-Lag][4];
            end
            tick(1);
        end
        idle(); tick(10);
        check_eq("rand_mismatch", 64'(mism0), 64'h0);
        check_eq("rand_overflow", 64'(ovf0), 64'h0);
        check_eq("rand_errcnt", 64'(err0), 64'h0);
        check_eq("rand_ign_mismatch", 64'(mism1), 64'h0);
        check_eq("rand_ign_overflow", 64'(ovf1), 64'h0);
        check_eq("rand_ign_errcnt", 64'(err1), 64'h0);

        // Reset asserted between clock edges while traffic and an error are live
        for (int unsigned k = 0; k < 6; k++) begin
            idle();
            a_req.aw = aw_q[k]; a_req.aw_valid = 1'b1;
            if (k == 2) begin
                a_rsp.r = r_q[0]; a_rsp.r_valid = 1'b1;
            end
            tick(1);
        end
        check_eq("mid_pre_errcnt", 64'(err0), 64'h1);
        check_eq("mid_pre_mismatch", 64'(mism0), 64'h10);
        #1 rst_1_n = 1'b1;
        #1;
        check_eq("mid_rst_mismatch", 64'(mism0), 64'h0);
        check_eq("mid_rst_overflow", 64'(ovf0), 64'h0);
        check_eq("mid_rst_errcnt", 64'(err0), 64'h0);
        idle();
        tick(2);
        rst_1_n = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
